// File: rtl/twos_comp_pkg.sv
// Shared types and constants for the serial two's-complement deserializer.
package twos_comp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/twos_comp_deser_negate.sv
// Bit-serial two's-complement negation: copy bits up to and including the first 1, invert the rest.
module serial_negate_cell (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic in_bit,
  output logic neg_bit
);

  logic flag;
  logic flag_eff;

  // A clear on the same cycle as an accepted bit makes that bit the first of a new word.
  assign flag_eff = clr ? 1'b0 : flag;
  assign neg_bit  = in_bit ^ flag_eff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flag <= 1'b0;
    end else if (en) begin
      flag <= flag_eff | in_bit;
    end else if (clr) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/twos_comp_deser.sv
// Deserializes LSB-first two's-complement words into sign + magnitude.
//   state | meaning
//   IDLE  | waiting for a start-of-frame bit
//   SHIFT | collecting bits 1..WIDTH-1 of the current word
module twos_comp_deser
  import twos_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_bit,
  output logic             out_valid,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_abort
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] neg;

  logic             sof_hit;
  logic             bit_hit;
  logic             neg_bit;
  logic [WIDTH-1:0] bit_sel;
  logic [WIDTH-1:0] raw_next;
  logic [WIDTH-1:0] neg_next;

  assign sof_hit  = in_valid & in_sof;
  assign bit_hit  = in_valid & ~in_sof & (state == SHIFT);
  assign bit_sel  = {{(WIDTH-1){1'b0}}, 1'b1} << count;
  assign raw_next = raw | (in_bit  ? bit_sel : '0);
  assign neg_next = neg | (neg_bit ? bit_sel : '0);

  serial_negate_cell u_neg (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (sof_hit),
    .en      (sof_hit | bit_hit),
    .in_bit  (in_bit),
    .neg_bit (neg_bit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      count     <= '0;
      raw       <= '0;
      neg       <= '0;
      out_valid <= 1'b0;
      out_abort <= 1'b0;
      out_sign  <= 1'b0;
      out_mag   <= '0;
    end else begin
      out_valid <= 1'b0;
      out_abort <= 1'b0;
      if (sof_hit) begin
        // An sof while collecting discards the partial word and restarts here.
        out_abort <= (state == SHIFT);
        raw       <= {{(WIDTH-1){1'b0}}, in_bit};
        neg       <= {{(WIDTH-1){1'b0}}, neg_bit};
        count     <= CW'(1);
        state     <= SHIFT;
      end else if (bit_hit) begin
        raw <= raw_next;
        neg <= neg_next;
        if (count == LAST) begin
          state     <= IDLE;
          count     <= '0;
          out_valid <= 1'b1;
          out_sign  <= in_bit;
          out_mag   <= in_bit ? neg_next : raw_next;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_twos_comp_deser.sv
// Directed bench for twos_comp_deser at WIDTH=8: vector table plus corner-case sequences.
module tb_twos_comp_deser;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         in_bit = 1'b0;
  logic         out_valid;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_abort;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acount = 0;
  int both_err = 0;

  logic [W-1:0] cap_mag[$];
  logic         cap_sign[$];
  int           cap_cyc[$];

  typedef struct {
    logic [W-1:0] w;
    int           gap_at;
    int           gap_len;
    logic         exp_sign;
    logic [W-1:0] exp_mag;
  } vec_t;

  vec_t vecs[9];

  twos_comp_deser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_abort (out_abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      cap_mag.push_back(out_mag);
      cap_sign.push_back(out_sign);
      cap_cyc.push_back(cyc);
    end
    if (out_abort) acount++;
    if (out_valid && out_abort) both_err++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic b);
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_bit   = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  // Gap cycles drive in_sof=1 with in_valid=0 to confirm sof is ignored when unqualified.
  task automatic send_bits(input logic [W-1:0] w, input int n, input int gap_at,
                           input int gap_len, output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, (i == 0), w[i]);
      last_cyc = cyc;
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) drive(1'b0, 1'b1, ~w[i]);
    end
  endtask

  task automatic check_one(input string name, input int q0, input int lc,
                           input logic s, input logic [W-1:0] m);
    chk({name, " count"}, cap_mag.size() - q0, 1);
    if (cap_mag.size() > q0) begin
      chk({name, " sign"}, cap_sign[q0], s);
      chk({name, " mag"}, cap_mag[q0], m);
      chk({name, " latency"}, cap_cyc[q0], lc + 1);
    end
  endtask

  initial begin
    int q0;
    int a0;
    int lc;
    int lc2;
    logic [W-1:0] w;

    vecs[0] = '{8'h05, -1, 0, 1'b0, 8'h05};
    vecs[1] = '{8'hFB,  2, 3, 1'b1, 8'h05};
    vecs[2] = '{8'h80, -1, 0, 1'b1, 8'h80};
    vecs[3] = '{8'h00, -1, 0, 1'b0, 8'h00};
    vecs[4] = '{8'hFF, -1, 0, 1'b1, 8'h01};
    vecs[5] = '{8'h7F,  0, 1, 1'b0, 8'h7F};
    vecs[6] = '{8'h81, -1, 0, 1'b1, 8'h7F};
    vecs[7] = '{8'hC0,  5, 2, 1'b1, 8'h40};
    vecs[8] = '{8'h01,  6, 1, 1'b0, 8'h01};

    #3;
    chk("rst out_valid", out_valid, 0);
    chk("rst out_abort", out_abort, 0);
    chk("rst out_sign", out_sign, 0);
    chk("rst out_mag", out_mag, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    foreach (vecs[k]) begin
      q0 = cap_mag.size();
      send_bits(vecs[k].w, W, vecs[k].gap_at, vecs[k].gap_len, lc);
      idle(3);
      #1;
      check_one($sformatf("vec%0d", k), q0, lc, vecs[k].exp_sign, vecs[k].exp_mag);
      chk($sformatf("vec%0d hold mag", k), out_mag, vecs[k].exp_mag);
      chk($sformatf("vec%0d hold valid", k), out_valid, 0);
    end

    // Back-to-back frames
    q0 = cap_mag.size();
    send_bits(8'h80, W, -1, 0, lc);
    send_bits(8'h00, W, -1, 0, lc2);
    idle(2);
    #1;
    chk("b2b count", cap_mag.size() - q0, 2);
    if (cap_mag.size() >= q0 + 2) begin
      chk("b2b first sign", cap_sign[q0], 1);
      chk("b2b first mag", cap_mag[q0], 8'h80);
      chk("b2b second sign", cap_sign[q0+1], 0);
      chk("b2b second mag", cap_mag[q0+1], 8'h00);
      chk("b2b spacing", cap_cyc[q0+1] - cap_cyc[q0], 8);
    end

    // Abort: partial 4-bit frame interrupted by a new sof
    q0 = cap_mag.size();
    a0 = acount;
    send_bits(8'hA5, 4, -1, 0, lc);
    send_bits(8'hFF, W, -1, 0, lc);
    idle(2);
    #1;
    chk("abort pulses", acount - a0, 1);
    check_one("abort frame", q0, lc, 1'b1, 8'h01);

    // Reset in mid-frame, then sof on the first edge after release
    q0 = cap_mag.size();
    a0 = acount;
    send_bits(8'h3C, 5, -1, 0, lc);
    @(negedge clk);
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 0);
    chk("midrst out_sign", out_sign, 0);
    chk("midrst out_mag", out_mag, 0);
    w = 8'h7F;
    @(negedge clk);
    rstn     = 1'b1;
    in_valid = 1'b1;
    in_sof   = 1'b1;
    in_bit   = w[0];
    for (int i = 1; i < W; i++) begin
      drive(1'b1, 1'b0, w[i]);
      lc = cyc;
    end
    idle(2);
    #1;
    chk("midrst abort", acount - a0, 0);
    check_one("post-rst frame", q0, lc, 1'b0, 8'h7F);

    // Unframed valid bits while IDLE are ignored
    q0 = cap_mag.size();
    a0 = acount;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, i[0]);
    idle(2);
    #1;
    chk("idle junk valid", cap_mag.size() - q0, 0);
    chk("idle junk abort", acount - a0, 0);
    send_bits(8'h3C, W, -1, 0, lc);
    idle(2);
    #1;
    check_one("after junk", q0, lc, 1'b0, 8'h3C);

    chk("valid/abort overlap", both_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
